// File: rtl/l1_l2_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_l2_arb_pkg
// Purpose  : Shared types and default widths for the L1-to-L2 request
//            arbiter and the L1 instruction/data cache controllers.
// Contents : arb_state_t (IDLE/BUSY/GAP), arb_op_t (OP_READ/OP_WRITE),
//            default tag/index widths for a 32-bit address with 64-byte lines
//            and 32 sets.
// Revision : 1.0 - initial release
// ============================================================================
package l1_l2_arb_pkg;

  // address[31:11] is the tag, address[10:6] the set index
  localparam int c_tag_w   = 21;
  localparam int c_index_w = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage : l1_l2_arb_pkg
`default_nettype wire

// File: rtl/l1_l2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l1_l2_arbiter_if
// Purpose  : Bundles the I-side, D-side and L2-side handshake signals of the
//            L1-to-L2 arbiter.
// Modports : slave  - arbiter view (requests in, L2 lines / ready pulses out)
//            master - environment view (L1 controllers and L2 together)
// Signals  : i_read_req/i_tag/i_index/i_ready          I-cache side
//            d_read_req/d_write_req/d_tag/d_write_tag/
//            d_index/d_ready                           D-cache side
//            read_L1_L2/write_L1_L2/tag_L1_L2/
//            index_L1_L2/ready_L2_L1                   L2 side
//            grant_d/busy                              status
// Revision : 1.0 - initial release
// ============================================================================
interface l1_l2_arbiter_if
  import l1_l2_arb_pkg::*;
#(
  parameter int TAG_W   = c_tag_w,
  parameter int INDEX_W = c_index_w
);

  logic               i_read_req;
  logic [TAG_W-1:0]   i_tag;
  logic [INDEX_W-1:0] i_index;
  logic               i_ready;

  logic               d_read_req;
  logic               d_write_req;
  logic [TAG_W-1:0]   d_tag;
  logic [TAG_W-1:0]   d_write_tag;
  logic [INDEX_W-1:0] d_index;
  logic               d_ready;

  logic               read_L1_L2;
  logic               write_L1_L2;
  logic [TAG_W-1:0]   tag_L1_L2;
  logic [INDEX_W-1:0] index_L1_L2;
  logic               ready_L2_L1;

  logic               grant_d;
  logic               busy;

  modport slave (
    input  i_read_req, i_tag, i_index,
    input  d_read_req, d_write_req, d_tag, d_write_tag, d_index,
    input  ready_L2_L1,
    output i_ready, d_ready,
    output read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2,
    output grant_d, busy
  );

  modport master (
    output i_read_req, i_tag, i_index,
    output d_read_req, d_write_req, d_tag, d_write_tag, d_index,
    output ready_L2_L1,
    input  i_ready, d_ready,
    input  read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2,
    input  grant_d, busy
  );

endinterface : l1_l2_arbiter_if
`default_nettype wire

// File: rtl/l1_l2_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Purpose  : Two-input round-robin picker. On a tie the side that did not
//            win last time is chosen.
// Ports    : req_a   in  1  request from side A
//            req_b   in  1  request from side B
//            last_b  in  1  1 = side B won the previous arbitration
//            grant_b out 1  1 = side B wins (only meaningful with valid)
//            valid   out 1  at least one side is requesting
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr2 (
  input  wire logic req_a,
  input  wire logic req_b,
  input  wire logic last_b,
  output logic      grant_b,
  output logic      valid
);

  // B wins when it is alone, or on a tie when A had the previous turn
  assign grant_b = req_b & (~req_a | ~last_b);
  assign valid   = req_a | req_b;

endmodule : arb_rr2
`default_nettype wire

// File: rtl/l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l1_l2_arbiter
// Purpose  : Shares one L2 request port between the L1 I-cache (refills) and
//            the L1 D-cache (refills and dirty write-backs). One transaction
//            is latched at a time, held on the L2 lines until ready_L2_L1,
//            and the ready pulse is routed back to the owner. A one-cycle GAP
//            after each completion keeps a stale request from being regranted.
// Ports    : clk   in  system clock, rising edge
//            nrst  in  asynchronous active-low reset
//            bus   slave modport of l1_l2_arbiter_if (all handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module l1_l2_arbiter
  import l1_l2_arb_pkg::*;
#(
  parameter int TAG_W   = c_tag_w,
  parameter int INDEX_W = c_index_w
) (
  input  wire logic          clk,
  input  wire logic          nrst,
  l1_l2_arbiter_if.slave     bus
);

  arb_state_t         r_state;
  logic               r_last_d;
  logic               r_grant_d;
  logic               r_busy;
  logic               r_read;
  logic               r_write;
  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_index;

  logic               w_d_req;
  logic               w_grant_d;
  logic               w_valid;
  arb_op_t            w_op;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;

  assign w_d_req = bus.d_read_req | bus.d_write_req;

  arb_rr2 u_rr2 (
    .req_a   (bus.i_read_req),
    .req_b   (w_d_req),
    .last_b  (r_last_d),
    .grant_b (w_grant_d),
    .valid   (w_valid)
  );

  // The D side flushes its victim before refilling, so a pending write-back
  // outranks a pending refill; the I side only ever reads.
  assign w_op    = (w_grant_d && bus.d_write_req) ? OP_WRITE : OP_READ;
  assign w_tag   = !w_grant_d        ? bus.i_tag :
                   bus.d_write_req   ? bus.d_write_tag : bus.d_tag;
  assign w_index = w_grant_d ? bus.d_index : bus.i_index;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_last_d  <= 1'b0;
      r_grant_d <= 1'b0;
      r_busy    <= 1'b0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_tag     <= '0;
      r_index   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant_d <= w_grant_d;
            r_busy    <= 1'b1;
            r_read    <= (w_op == OP_READ);
            r_write   <= (w_op == OP_WRITE);
            r_tag     <= w_tag;
            r_index   <= w_index;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.ready_L2_L1) begin
            r_busy   <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_last_d <= r_grant_d;
            r_state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.read_L1_L2  = r_read;
  assign bus.write_L1_L2 = r_write;
  assign bus.tag_L1_L2   = r_tag;
  assign bus.index_L1_L2 = r_index;
  assign bus.grant_d     = r_grant_d;
  assign bus.busy        = r_busy;

  // Zero-latency completion: forward the L2 pulse only while a transaction
  // is outstanding, so pulses in IDLE or GAP are dropped.
  assign bus.i_ready = bus.ready_L2_L1 & (r_state == ST_BUSY) & ~r_grant_d;
  assign bus.d_ready = bus.ready_L2_L1 & (r_state == ST_BUSY) &  r_grant_d;

endmodule : l1_l2_arbiter
`default_nettype wire

// File: tb/tb_l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_l2_arbiter
// Purpose  : Self-checking bench for l1_l2_arbiter: directed scenarios
//            followed by random stimulus, compared every cycle against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_l2_arbiter;

  localparam int TAG_W   = 21;
  localparam int INDEX_W = 5;

  logic clk;
  logic nrst;

  int checks;
  int errors;

  l1_l2_arbiter_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) bus ();

  l1_l2_arbiter #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  bit                 m_active;   // a transaction owns the L2 port
  bit                 m_owner_d;  // owner of current/last transaction
  bit                 m_write;
  logic [TAG_W-1:0]   m_tag;
  logic [INDEX_W-1:0] m_index;
  bit                 m_last_d;
  int                 m_free_at;  // first edge number at which a grant may happen
  int                 cyc;        // number of rising edges seen out of reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_owner_d = 0;
    m_write   = 0;
    m_tag     = '0;
    m_index   = '0;
    m_last_d  = 0;
    m_free_at = 0;
    cyc       = 0;
  endtask

  // Applies the arbitration rules to the inputs seen at this rising edge.
  task automatic model_edge();
    bit d_req;
    d_req = bus.d_read_req | bus.d_write_req;
    if (m_active) begin
      if (bus.ready_L2_L1) begin
        m_active  = 0;
        m_last_d  = m_owner_d;
        m_free_at = cyc + 2;   // one dead cycle after the completion
      end
    end else if (cyc >= m_free_at && (bus.i_read_req || d_req)) begin
      if (bus.i_read_req && d_req) m_owner_d = !m_last_d;
      else                         m_owner_d = d_req;
      m_active = 1;
      if (m_owner_d) begin
        m_write = bus.d_write_req;
        m_tag   = bus.d_write_req ? bus.d_write_tag : bus.d_tag;
        m_index = bus.d_index;
      end else begin
        m_write = 0;
        m_tag   = bus.i_tag;
        m_index = bus.i_index;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check("read_L1_L2",  {31'd0, bus.read_L1_L2},  {31'd0, m_active & !m_write});
    check("write_L1_L2", {31'd0, bus.write_L1_L2}, {31'd0, m_active &  m_write});
    check("tag_L1_L2",   32'(bus.tag_L1_L2),       32'(m_tag));
    check("index_L1_L2", 32'(bus.index_L1_L2),     32'(m_index));
    check("busy",        {31'd0, bus.busy},        {31'd0, m_active});
    check("grant_d",     {31'd0, bus.grant_d},     {31'd0, m_owner_d});
    check("i_ready",     {31'd0, bus.i_ready},     {31'd0, bus.ready_L2_L1 & m_active & !m_owner_d});
    check("d_ready",     {31'd0, bus.d_ready},     {31'd0, bus.ready_L2_L1 & m_active &  m_owner_d});
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_read_req  = 0;
    bus.i_tag       = '0;
    bus.i_index     = '0;
    bus.d_read_req  = 0;
    bus.d_write_req = 0;
    bus.d_tag       = '0;
    bus.d_write_tag = '0;
    bus.d_index     = '0;
    bus.ready_L2_L1 = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},  {31'd0, bus.read_L1_L2}, 32'd0);
    check({tag, "_write"}, {31'd0, bus.write_L1_L2}, 32'd0);
    check({tag, "_tag"},   32'(bus.tag_L1_L2), 32'd0);
    check({tag, "_index"}, 32'(bus.index_L1_L2), 32'd0);
    check({tag, "_iready"}, {31'd0, bus.i_ready}, 32'd0);
    check({tag, "_dready"}, {31'd0, bus.d_ready}, 32'd0);
    check({tag, "_grant"}, {31'd0, bus.grant_d}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bit       prev_busy;
    bit       grants[$];
    int       n_ready;

    checks = 0;
    errors = 0;
    clear_inputs();
    model_reset();

    // ---- power-on reset ----
    nrst = 0;
    repeat (2) @(negedge clk);
    bus.ready_L2_L1 = 1;
    #1;
    check_all_zero("por");
    bus.ready_L2_L1 = 0;
    nrst = 1;

    // ---- single I read, ready on the 4th busy cycle ----
    bus.i_read_req = 1; bus.i_tag = 21'h000123; bus.i_index = 5'd5;
    step();
    repeat (3) step();
    bus.ready_L2_L1 = 1; step();
    bus.ready_L2_L1 = 0; bus.i_read_req = 0;
    repeat (2) step();

    // ---- D write-back then refill ----
    bus.d_write_req = 1; bus.d_read_req = 1;
    bus.d_write_tag = 21'h0AAAAA; bus.d_tag = 21'h155555; bus.d_index = 5'd9;
    repeat (2) step();
    bus.ready_L2_L1 = 1; step();
    bus.ready_L2_L1 = 0; bus.d_write_req = 0;
    repeat (3) step();
    bus.ready_L2_L1 = 1; step();
    bus.ready_L2_L1 = 0; bus.d_read_req = 0;
    repeat (2) step();

    // ---- ready pulses with nothing outstanding ----
    bus.ready_L2_L1 = 1;
    repeat (2) step();
    bus.ready_L2_L1 = 0;

    // ---- I drops its request while BUSY ----
    bus.i_read_req = 1; bus.i_tag = 21'h0F0F0F; bus.i_index = 5'd17;
    step();
    step();
    bus.i_read_req = 0;
    repeat (2) step();
    bus.ready_L2_L1 = 1; step();
    bus.ready_L2_L1 = 0;
    repeat (3) step();

    // ---- reset in the middle of a D write ----
    bus.d_write_req = 1; bus.d_write_tag = 21'h1ABCDE; bus.d_index = 5'd3;
    repeat (2) step();
    nrst = 0;
    bus.ready_L2_L1 = 1;
    #1;
    check_all_zero("midrst");
    bus.ready_L2_L1 = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    nrst = 1;

    // ---- continuous I and D reads: grants must alternate, D first ----
    bus.i_read_req = 1; bus.i_tag = 21'h000777;
    bus.d_read_req = 1; bus.d_tag = 21'h000888; bus.d_index = 5'd1;
    prev_busy = 0;
    n_ready   = 0;
    for (int k = 0; k < 100 && grants.size() < 6; k++) begin
      bus.ready_L2_L1 = (bus.busy && n_ready == 1);
      step();
      if (bus.busy) n_ready++; else n_ready = 0;
      if (bus.busy && !prev_busy) grants.push_back(bus.grant_d);
      prev_busy = bus.busy;
    end
    check("alt_count", grants.size(), 32'd6);
    for (int k = 0; k < grants.size(); k++)
      check($sformatf("alt_grant%0d", k), {31'd0, grants[k]}, {31'd0, (k % 2) == 0});
    bus.ready_L2_L1 = 0;
    // finish the outstanding transaction
    for (int k = 0; k < 8; k++) begin
      bus.ready_L2_L1 = bus.busy;
      step();
    end
    clear_inputs();
    repeat (2) step();

    // ---- random traffic ----
    for (int k = 0; k < 4000; k++) begin
      bus.i_read_req  = ($urandom_range(0, 2) != 0);
      bus.d_read_req  = ($urandom_range(0, 2) != 0);
      bus.d_write_req = ($urandom_range(0, 3) == 0);
      bus.i_tag       = TAG_W'($urandom);
      bus.d_tag       = TAG_W'($urandom);
      bus.d_write_tag = TAG_W'($urandom);
      bus.i_index     = INDEX_W'($urandom);
      bus.d_index     = INDEX_W'($urandom);
      bus.ready_L2_L1 = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_l1_l2_arbiter
`default_nettype wire
